// File: rtl/det3x3_seq_pkg.sv
// det3x3_seq_pkg: shared definitions for the 3x3 determinant sequencer.
//   - FSM state encoding (IDLE, M0, M1, M2, P2)
//   - mode encoding (3x3 cofactor expansion vs. direct 2x2)
//   - element indices used to pick minor operands out of the latched
//     row-major matrix e0..e8
package det3x3_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_P2   = 3'd4
  } state_e;

  localparam logic MODE_3X3 = 1'b0;
  localparam logic MODE_2X2 = 1'b1;

  // Row-major element positions: row r, column c -> 3*r + c.
  localparam int unsigned E0 = 32'd0;
  localparam int unsigned E1 = 32'd1;
  localparam int unsigned E2 = 32'd2;
  localparam int unsigned E3 = 32'd3;
  localparam int unsigned E4 = 32'd4;
  localparam int unsigned E5 = 32'd5;
  localparam int unsigned E6 = 32'd6;
  localparam int unsigned E7 = 32'd7;
  localparam int unsigned E8 = 32'd8;

endpackage

// File: rtl/mod_determinante_2x2.sv
// mod_determinante_2x2: purely combinational 2x2 determinant mod 2^W.
// Lives outside det3x3_seq so a parent can share it between users.
// Ports:
//   a, b, c, d : matrix [[a,b],[c,d]]
//   res        : a*d - b*c, truncated to W bits
module mod_determinante_2x2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] res
);

  // Both products and the difference are evaluated at W bits, so they wrap.
  assign res = (a * d) - (b * c);

endmodule

// File: rtl/det3x3_seq.sv
// det3x3_seq: sequences a 3x3 determinant (mod 2^W) through one shared
// external 2x2 determinant unit using cofactor expansion along row 0:
//   det = e0*|e4 e5;e7 e8| - e1*|e3 e5;e6 e8| + e2*|e3 e4;e6 e7|
// One minor is issued per cycle (M0, M1, M2). Mode 1 runs a single pass
// (P2) returning |e0 e1;e3 e4|.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   start, mode, mat     : request; sampled together, only while idle
//   m2_a..m2_d           : operands presented to the shared 2x2 unit
//   m2_res               : combinational result from the 2x2 unit
//   busy                 : operation in flight (state-decoded)
//   done                 : one-cycle completion pulse (registered)
//   result               : determinant, held until the next completion
module det3x3_seq
  import det3x3_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic [9*W-1:0] mat,
  output logic [W-1:0]   m2_a,
  output logic [W-1:0]   m2_b,
  output logic [W-1:0]   m2_c,
  output logic [W-1:0]   m2_d,
  input  logic [W-1:0]   m2_res,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result
);

  state_e         state_q;
  logic [9*W-1:0] mat_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   result_q;
  logic           done_q;

  logic [W-1:0]   e_s [9];
  logic [W-1:0]   weight_s;
  logic [W-1:0]   prod_s;

  // Unpack the latched matrix into individual elements.
  for (genvar gi = 0; gi < 9; gi++) begin : g_elem
    assign e_s[gi] = mat_q[W*gi +: W];
  end

  // Minor operand and row-0 weight selection for the current state.
  always_comb begin
    m2_a     = '0;
    m2_b     = '0;
    m2_c     = '0;
    m2_d     = '0;
    weight_s = '0;
    case (state_q)
      ST_M0: begin
        m2_a     = e_s[E4];
        m2_b     = e_s[E5];
        m2_c     = e_s[E7];
        m2_d     = e_s[E8];
        weight_s = e_s[E0];
      end
      ST_M1: begin
        m2_a     = e_s[E3];
        m2_b     = e_s[E5];
        m2_c     = e_s[E6];
        m2_d     = e_s[E8];
        weight_s = e_s[E1];
      end
      ST_M2: begin
        m2_a     = e_s[E3];
        m2_b     = e_s[E4];
        m2_c     = e_s[E6];
        m2_d     = e_s[E7];
        weight_s = e_s[E2];
      end
      ST_P2: begin
        m2_a     = e_s[E0];
        m2_b     = e_s[E1];
        m2_c     = e_s[E3];
        m2_d     = e_s[E4];
        weight_s = '0;
      end
      default: begin
        m2_a     = '0;
        m2_b     = '0;
        m2_c     = '0;
        m2_d     = '0;
        weight_s = '0;
      end
    endcase
  end

  // Weighted minor, truncated to W bits (the upper product half is dropped).
  assign prod_s = weight_s * m2_res;

  // Sequencer FSM: latches the request, accumulates signed cofactor terms,
  // and registers result/done on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mat_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mat_q   <= mat;
            state_q <= (mode == MODE_2X2) ? ST_P2 : ST_M0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_M0: begin
          acc_q   <= prod_s;
          state_q <= ST_M1;
        end
        ST_M1: begin
          // Middle cofactor carries a negative sign.
          acc_q   <= acc_q - prod_s;
          state_q <= ST_M2;
        end
        ST_M2: begin
          result_q <= acc_q + prod_s;
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        ST_P2: begin
          result_q <= m2_res;
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // busy is decoded from the state register only, so start cannot reach it.
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_det3x3_seq.sv
// tb_det3x3_seq: directed scoreboard bench for det3x3_seq wired to a
// mod_determinante_2x2 instance. Expected results are pushed when a request
// is issued; a monitor pops and compares on every done pulse.
module tb_det3x3_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           mode;
  logic [9*W-1:0] mat;
  logic [W-1:0]   m2_a, m2_b, m2_c, m2_d, m2_res;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q [$];

  det3x3_seq #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .mat    (mat),
    .m2_a   (m2_a),
    .m2_b   (m2_b),
    .m2_c   (m2_c),
    .m2_d   (m2_d),
    .m2_res (m2_res),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  mod_determinante_2x2 #(.W(W)) u_m2 (
    .a   (m2_a),
    .b   (m2_b),
    .c   (m2_c),
    .d   (m2_d),
    .res (m2_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9*W-1:0] mk(
    input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
    input logic [7:0] a3, input logic [7:0] a4, input logic [7:0] a5,
    input logic [7:0] a6, input logic [7:0] a7, input logic [7:0] a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [9*W-1:0] m, input logic md);
    mat   = m;
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string nm);
    int n;
    n = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    chk(nm, n, lat);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: result %0d with no request outstanding", result);
      end else begin
        chk("result", {24'd0, result}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] rnd;
    logic [9*W-1:0] ident, m123, wrapm, m2x2, diag;
    ident = mk(8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1);
    m123  = mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10);
    wrapm = mk(8'd16, 8'd0, 8'd0, 8'd0, 8'd16, 8'd0, 8'd0, 8'd0, 8'd1);
    m2x2  = mk(8'd5, 8'd3, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
    diag  = mk(8'd2, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd4);

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    mat   = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_m2", {m2_a, m2_b, m2_c, m2_d}, 32'd0);
    rst_n = 1'b1;

    // Identity, 3x3: busy through M0..M2, done 3 edges after sampling.
    exp_q.push_back(8'd1);
    issue(ident, 1'b0);
    chk("id_busy", {31'd0, busy}, 32'd1);
    wait_done(3, "id_latency");
    chk("id_busy_done", {31'd0, busy}, 32'd0);

    // [[1,2,3],[4,5,6],[7,8,10]] -> -3 mod 256, with per-state minor operands.
    exp_q.push_back(8'd253);
    issue(m123, 1'b0);
    chk("m2_M0", {m2_a, m2_b, m2_c, m2_d}, {8'd5, 8'd6, 8'd8, 8'd10});
    tick();
    chk("m2_M1", {m2_a, m2_b, m2_c, m2_d}, {8'd4, 8'd6, 8'd7, 8'd10});
    tick();
    chk("m2_M2", {m2_a, m2_b, m2_c, m2_d}, {8'd4, 8'd5, 8'd7, 8'd8});
    tick();
    chk("m123_done", {31'd0, done}, 32'd1);
    chk("m123_m2_idle", {m2_a, m2_b, m2_c, m2_d}, 32'd0);

    // Wrap: 16*16 = 256 -> 0. Then direct 2x2: 5*1 - 3*2 = -1 -> 255.
    exp_q.push_back(8'd0);
    issue(wrapm, 1'b0);
    wait_done(3, "wrap_latency");
    exp_q.push_back(8'd255);
    issue(m2x2, 1'b1);
    chk("p2_busy", {31'd0, busy}, 32'd1);
    wait_done(1, "p2_latency");

    // Back-to-back: second start in the done cycle; stray start in M1 ignored.
    exp_q.push_back(8'd24);
    issue(diag, 1'b0);
    wait_done(3, "diag_latency");
    exp_q.push_back(8'd1);
    issue(ident, 1'b0);
    tick();
    mat   = m2x2;
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy_M2", {31'd0, busy}, 32'd1);
    tick();
    chk("b2b_done", {31'd0, done}, 32'd1);
    repeat (6) tick();
    chk("b2b_no_extra", {31'd0, busy}, 32'd0);

    // Reset during M1 aborts at once; no done afterwards.
    issue(m123, 1'b0);
    tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_m2", {m2_a, m2_b, m2_c, m2_d}, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_abort_busy", {31'd0, busy}, 32'd0);
    chk("post_abort_result", {24'd0, result}, 32'd0);

    // Result hold: matrix changes with start low must not disturb anything.
    exp_q.push_back(8'd255);
    issue(m2x2, 1'b1);
    wait_done(1, "hold_latency");
    for (int i = 0; i < 10; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      mat = rnd[9*W-1:0];
      tick();
      chk("hold_result", {24'd0, result}, 32'd255);
      chk("hold_busy", {31'd0, busy}, 32'd0);
      chk("hold_done", {31'd0, done}, 32'd0);
    end

    repeat (2) tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/det3x3_seq.md
Name: det3x3_seq

Overview:
- Sequencer that computes a 3x3 determinant mod 2^W by cofactor expansion along row 0.
- Issues three 2x2 minors, one per cycle, to a single shared 2x2 determinant unit, then weights, signs and accumulates them.
- The 2x2 unit (mod_determinante_2x2) sits outside this block and connects through the m2_* ports, so the top level can share it.
- Also supports a direct 2x2 mode, which is a single pass through the shared unit.

Parameters:
- W, 8, element, product and result width; all arithmetic is modulo 2^W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = 3x3 determinant, 1 = 2x2 determinant of e0,e1,e3,e4; sampled with start.
- mat  in  9*W  row-major elements e0..e8; element i is at [W*i+W-1 : W*i]; sampled with start.
- m2_a, m2_b, m2_c, m2_d  out  W each  operands to the shared 2x2 unit.
- m2_res  in  W  combinational result from the 2x2 unit, equal to a*d - b*c mod 2^W.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  W  determinant mod 2^W; holds until the next completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, accumulator=0, latched matrix=0, m2_* outputs=0.
- States:
  - IDLE: start=1 latches mat and mode. Next state is M0 (mode 0) or P2 (mode 1). busy=0.
  - M0: minor (e4,e5,e7,e8). acc <= e0*m2_res. Next M1.
  - M1: minor (e3,e5,e6,e8). acc <= acc - e1*m2_res. Next M2.
  - M2: minor (e3,e4,e6,e7). result <= acc + e2*m2_res. done <= 1. Next IDLE.
  - P2: minor (e0,e1,e3,e4). result <= m2_res. done <= 1. Next IDLE.
- m2_a..m2_d are combinational from state and the latched matrix; they are 0 in IDLE.
- Products are truncated to their low W bits; add and subtract wrap mod 2^W with no saturation or overflow flag.
- busy=1 in M0, M1, M2 and P2; it is a registered or state-decoded output with no combinational path from start.
- Latency from the clock edge that samples start to the edge that raises done:
  - mode 0: 3 edges.
  - mode 1: 1 edge.
- done is high for exactly one cycle.
- start while busy=1 is ignored, with no queueing. mat and mode changes while busy have no effect.
- start in the cycle done is high: the FSM is in IDLE, so start is accepted and the new operation begins with no bubble.
- result changes only at completion; it is stable between done pulses.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced for the aborted operation.
- The 2x2 unit is purely combinational. m2_res is sampled on the same edge that its operands were presented.

Decomposition:
- Shared package:
  - state encoding constants: IDLE, M0, M1, M2, P2.
  - mode constants: MODE_3X3=0, MODE_2X2=1.
  - element index constants for the minor operand selection.
- No sub-module inside this block. The weighted multiply is one inline W x W product truncated to W bits.
- mod_determinante_2x2 is instantiated by the parent, or by the bench, and wired to m2_*.

Test Plan:
- Identity matrix (e0=e4=e8=1, others 0), mode 0, start pulse -> busy high for 3 cycles, done pulse on the 3rd edge, result=1.
- [[1,2,3],[4,5,6],[7,8,10]] mode 0 -> result=253 (−3 mod 256). Check m2_* per state: M0 (5,6,8,10), M1 (4,6,7,10), M2 (4,5,7,8).
- Wrap: [[16,0,0],[0,16,0],[0,0,1]] mode 0 -> result=0. Then a 2x2 run with e0=5, e1=3, e3=2, e4=1, mode 1 -> done after 1 edge, result=255.
- Back-to-back: second start asserted in the done cycle with an identity matrix -> accepted. Second done comes 3 edges later with result=1. A start pulsed in M1 produces no extra operation.
- Reset mid-operation: assert rst_n=0 in M1 -> busy, done, result and m2_* go to 0 immediately. After release, no done appears until a new start.
- Result hold: after completion, change mat for 10 cycles with start=0 -> result and busy unchanged, done stays 0.
